// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler with a one-entry valid/ready output slot.
// Completed words that find the slot occupied and not draining are dropped and flagged as overflow.
module serial_word_assembler #(
  parameter int unsigned WIDTH     = 5,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  input  logic                       flush,
  output logic [WIDTH-1:0]           word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [$clog2(WIDTH+1)-1:0] bit_count,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StEmpty, StFull} slot_e;

  slot_e            state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] shifted;
  logic             accept, complete, load, drop;

  always_comb begin
    shifted = '0;
    if (MSB_FIRST) begin
      shifted = {shreg_q[WIDTH-2:0], bit_in};
    end else begin
      shifted = {bit_in, shreg_q[WIDTH-1:1]};
    end
  end

  // flush takes priority over a bit arriving on the same edge
  assign accept   = bit_valid & ~flush;
  assign complete = accept & (cnt_q == CntW'(WIDTH - 1));
  assign load     = complete & ((state_q == StEmpty) | word_ready);
  assign drop     = complete & (state_q == StFull) & ~word_ready;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (flush || complete) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (accept) begin
      shreg_d = shifted;
      cnt_d   = cnt_q + CntW'(1);
    end
  end

  always_comb begin
    word_d = load ? shifted : word_q;
    // a drop wins over a simultaneous clear
    ovf_d  = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  // Output slot FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Output slot FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (complete) state_d = StFull;
      StFull:  if (word_ready && !complete) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // Output slot FSM: outputs
  always_comb begin
    word_valid = (state_q == StFull);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign word_out  = word_q;
  assign bit_count = cnt_q;
  assign overflow  = ovf_q;

endmodule
